// File: rtl/obi_data_arbiter.sv
// Two-master OBI data-port arbiter: round-robin address phase, in-order
// response steering through a small ID FIFO, sticky protocol-error flag.
module obi_data_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // master 0: core data interface
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_err_o,
  // master 1: auxiliary loader
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_err_o,
  // memory side
  output logic                s_req_o,
  input  logic                s_gnt_i,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_be_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_err_i,
  output logic                protocol_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

  logic                 prio;
  logic [MAX_OUTST-1:0] id_fifo;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 protocol_err;

  logic sel;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic head_id;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_MAX);
  assign head_id    = id_fifo[rd_ptr];

  // Pick the requester: sole requester wins, otherwise the favoured one.
  always_comb begin
    sel = 1'b0;
    if (m0_req_i && m1_req_i) sel = prio;
    else if (m1_req_i)        sel = 1'b1;
  end

  assign s_req_o   = ~rst_i & (m0_req_i | m1_req_i) & ~fifo_full;
  assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = sel ? m1_we_i    : m0_we_i;
  assign s_be_o    = sel ? m1_be_i    : m0_be_i;
  assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign push = s_req_o & s_gnt_i;
  assign pop  = ~rst_i & s_rvalid_i & ~fifo_empty;

  assign m0_gnt_o = push & ~sel;
  assign m1_gnt_o = push &  sel;

  // Only rvalid is steered; data and error go to both masters.
  assign m0_rvalid_o = pop & ~head_id;
  assign m1_rvalid_o = pop &  head_id;
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;
  assign m0_err_o    = s_err_i;
  assign m1_err_o    = s_err_i;

  assign protocol_err_o = protocol_err;

  // Arbitration priority, ID FIFO bookkeeping and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio         <= 1'b0;
      id_fifo      <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
        prio            <= ~sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_rvalid_i && fifo_empty) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Self-checking bench for obi_data_arbiter: the bench plays both masters and
// the memory; accepted transactions go into a scoreboard queue and are checked
// against the steered response when the memory answers.
module tb_obi_data_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o, m0_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [3:0]  m0_be_i;
  logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o, m1_err_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [3:0]  m1_be_i;
  logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_err_i, protocol_err_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [3:0]  s_be_o;

  obi_data_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          id;
    logic [31:0] data;
    bit          err;
  } sb_t;
  sb_t sb[$];

  typedef struct packed {
    bit r0, r1, g, rsp;          // inputs
    bit e_req, e_g0, e_g1, e_sel; // expected address-phase outputs
  } vec_t;
  vec_t tbl[14];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] a0 = 32'h100;
  logic [31:0] a1 = 32'h2000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_payload();
    m0_addr_i  = a0;  m0_we_i = 1'b0; m0_be_i = 4'hF; m0_wdata_i = a0 + 32'd1;
    m1_addr_i  = a1;  m1_we_i = 1'b1; m1_be_i = 4'h3; m1_wdata_i = a1 ^ 32'h5555_5555;
  endtask

  // One clock of stimulus plus all checks for that cycle.
  task automatic cycle(input string tag, input bit r0, input bit r1, input bit g, input bit rsp,
                       input bit e_req, input bit e_g0, input bit e_g1, input bit e_sel,
                       input bit e_perr);
    sb_t e;
    @(posedge clk); #1;
    m0_req_i = r0; m1_req_i = r1; s_gnt_i = g;
    drive_payload();
    s_rvalid_i = rsp;
    if (rsp && sb.size() > 0) begin
      s_rdata_i = sb[0].data; s_err_i = sb[0].err;
    end else begin
      s_rdata_i = $urandom; s_err_i = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".s_req"}, s_req_o, e_req);
    chk({tag, ".gnt0"}, m0_gnt_o, e_g0);
    chk({tag, ".gnt1"}, m1_gnt_o, e_g1);
    chk({tag, ".s_addr"}, s_addr_o, e_sel ? a1 : a0);
    chk({tag, ".s_we_be_wdata"}, {s_we_o, s_be_o, s_wdata_o},
        e_sel ? {1'b1, 4'h3, a1 ^ 32'h5555_5555} : {1'b0, 4'hF, a0 + 32'd1});
    chk({tag, ".perr"}, protocol_err_o, e_perr);
    if (rsp && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rvalid"}, {m1_rvalid_o, m0_rvalid_o}, e.id ? 2'b10 : 2'b01);
      chk({tag, ".rdata"}, {m0_rdata_o, m1_rdata_o}, {e.data, e.data});
      chk({tag, ".err"}, {m0_err_o, m1_err_o}, {e.err, e.err});
    end else begin
      chk({tag, ".no_rvalid"}, {m1_rvalid_o, m0_rvalid_o}, 2'b00);
    end
    if (e_req && g) begin
      e.id   = e_sel;
      e.data = mem_word(e_sel ? a1 : a0);
      e.err  = e_sel ? a1[2] : a0[2];
      sb.push_back(e);
      if (e_sel) a1 += 32'd4; else a0 += 32'd4;
    end
  endtask

  task automatic idle_inputs();
    m0_req_i = 1'b0; m1_req_i = 1'b0; s_gnt_i = 1'b0;
    s_rvalid_i = 1'b0; s_rdata_i = '0; s_err_i = 1'b0;
    drive_payload();
  endtask

  // Reset with every request line and a stray response active; outputs must stay gated.
  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_i = 1'b1;
    m0_req_i = 1'b1; m1_req_i = 1'b1; s_gnt_i = 1'b1; s_rvalid_i = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_s_req"}, s_req_o, 1'b0);
    chk({tag, ".rst_gnt"}, {m0_gnt_o, m1_gnt_o}, 2'b00);
    chk({tag, ".rst_rvalid"}, {m0_rvalid_o, m1_rvalid_o}, 2'b00);
    @(posedge clk); #1;
    rst_i = 1'b0;
    idle_inputs();
    sb.delete();
  endtask

  initial begin
    int cnt;
    bit p;
    rst_i = 1'b1;
    idle_inputs();
    tbl[0]  = '{0,0,0,0, 0,0,0,0};
    tbl[1]  = '{1,1,1,0, 1,1,0,0};
    tbl[2]  = '{1,1,1,1, 1,0,1,1};
    tbl[3]  = '{1,1,1,1, 1,1,0,0};
    tbl[4]  = '{1,1,1,0, 1,0,1,1};
    tbl[5]  = '{1,1,1,0, 0,0,0,0};
    tbl[6]  = '{1,1,1,1, 0,0,0,0};
    tbl[7]  = '{1,1,1,1, 1,1,0,0};
    tbl[8]  = '{0,1,0,0, 1,0,0,1};
    tbl[9]  = '{1,0,1,0, 1,1,0,0};
    tbl[10] = '{0,0,0,1, 0,0,0,0};
    tbl[11] = '{0,0,0,1, 0,0,0,0};
    tbl[12] = '{0,1,1,0, 1,0,1,1};
    tbl[13] = '{0,0,0,1, 0,0,0,0};

    repeat (2) @(posedge clk);
    do_reset("init");
    cycle("reset_idle", 0,0,0,0, 0,0,0,0, 0);

    // Single m0 read of 0x100 answered the next cycle with 0xDEADBEEF.
    cycle("t1_req", 1,0,1,0, 1,1,0,0, 0);
    cycle("t1_rsp", 0,0,0,1, 0,0,0,0, 0);
    chk("t1.rdata_value", m0_rdata_o, 32'hDEADBEEF);

    // Round-robin, full-FIFO stall and routing from a known reset state.
    do_reset("tbl");
    foreach (tbl[i])
      cycle($sformatf("vec%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].g, tbl[i].rsp,
            tbl[i].e_req, tbl[i].e_g0, tbl[i].e_g1, tbl[i].e_sel, 0);

    // Sustained traffic around the full boundary with push+pop overlap and pointer wrap.
    cycle("wrap_fill", 1,1,1,0, 1,1,0,0, 0);
    cnt = 1; p = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bit rsp, er;
      rsp = (i % 3) != 0;
      er  = cnt < 2;
      cycle($sformatf("wrap%0d", i), 1,1,1,rsp, er, er && !p, er && p, p, 0);
      if (er) begin p = ~p; cnt++; end
      if (rsp) cnt--;
    end
    for (int i = 0; i < 4 && cnt > 0; i++) begin
      cycle($sformatf("drain%0d", i), 0,0,0,1, 0,0,0,0, 0);
      cnt--;
    end
    chk("drain.sb_empty", sb.size(), 0);

    // Response with nothing outstanding sets a sticky error cleared only by reset.
    cycle("perr_rsp", 0,0,0,1, 0,0,0,0, 0);
    for (int i = 0; i < 3; i++) cycle($sformatf("perr_hold%0d", i), 0,0,0,0, 0,0,0,0, 1);
    do_reset("perr");
    cycle("perr_cleared", 0,0,0,0, 0,0,0,0, 0);

    // Reset with one outstanding: prio back to m0, FIFO emptied, m1 served at once.
    cycle("r6_m0", 1,0,1,0, 1,1,0,0, 0);
    do_reset("r6");
    cycle("r6_prio", 1,1,0,0, 1,0,0,0, 0);
    cycle("r6_m1", 0,1,1,0, 1,0,1,1, 0);
    cycle("r6_m1_rsp", 0,0,0,1, 0,0,0,0, 0);

    // Late memory response after a reset that dropped an outstanding ID.
    cycle("late_req", 1,0,1,0, 1,1,0,0, 0);
    do_reset("late");
    cycle("late_rsp", 0,0,0,1, 0,0,0,0, 0);
    cycle("late_perr", 0,0,0,0, 0,0,0,0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
